// File: rtl/pwm_register_access_controller_if.sv
// Byte-level bus between the serial slave front-end / register bank and the
// register access controller. The controller connects through the slave modport.
interface pwm_register_access_controller_if #(
  parameter int unsigned AddressWidth = 8
);
  logic                    StartMatch;
  logic                    RnW;
  logic                    Stop;
  logic                    RxValid;
  logic [7:0]              RxData;
  logic                    TxReq;
  logic [7:0]              TxData;
  logic                    TxValid;
  logic [AddressWidth-1:0] RdAddr;
  logic [7:0]              RegRdData;
  logic [AddressWidth-1:0] WrAddr;
  logic [7:0]              WrData;
  logic                    WrEn;
  logic                    Busy;
  logic                    RangeErr;

  modport master (
    output StartMatch, RnW, Stop, RxValid, RxData, TxReq, RegRdData,
    input  TxData, TxValid, RdAddr, WrAddr, WrData, WrEn, Busy, RangeErr
  );

  modport slave (
    input  StartMatch, RnW, Stop, RxValid, RxData, TxReq, RegRdData,
    output TxData, TxValid, RdAddr, WrAddr, WrData, WrEn, Busy, RangeErr
  );
endinterface

// File: rtl/pwm_register_access_controller.sv
// Transaction sequencer: first write byte sets the register pointer, further
// bytes stream into / out of consecutive registers with range gating.
module pwm_register_access_controller #(
  parameter int unsigned AddressWidth = 8,
  parameter int unsigned NumRegs      = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  pwm_register_access_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GET_ADDR   = 2'd1,
    WRITE_DATA = 2'd2,
    READ_DATA  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [AddressWidth-1:0] ptr_q, ptr_d;
  logic [AddressWidth-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]              wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    range_err_q, range_err_d;
  logic                    in_range;

  assign in_range = (32'(ptr_q) < NumRegs);

  // State and datapath registers, synchronous reset discards pending strobes
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      range_err_q <= range_err_d;
    end
  end

  // Next state: StartMatch beats Stop beats byte events
  always_comb begin
    state_d = state_q;
    if (bus.StartMatch) begin
      state_d = bus.RnW ? READ_DATA : GET_ADDR;
    end else if (bus.Stop) begin
      state_d = IDLE;
    end else if (state_q == GET_ADDR && bus.RxValid) begin
      state_d = WRITE_DATA;
    end
  end

  // Datapath next values; bytes/requests coinciding with Start/Stop are dropped
  always_comb begin
    ptr_d       = ptr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    range_err_d = range_err_q;
    if (bus.StartMatch) begin
      range_err_d = 1'b0;
    end else if (!bus.Stop) begin
      unique case (state_q)
        GET_ADDR: begin
          if (bus.RxValid) begin
            ptr_d = AddressWidth'(bus.RxData);
          end
        end
        WRITE_DATA: begin
          if (bus.RxValid) begin
            ptr_d = ptr_q + AddressWidth'(1);
            if (in_range) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = bus.RxData;
            end else begin
              range_err_d = 1'b1;
            end
          end
        end
        READ_DATA: begin
          if (bus.TxReq) begin
            ptr_d      = ptr_q + AddressWidth'(1);
            tx_valid_d = 1'b1;
            if (in_range) begin
              tx_data_d = bus.RegRdData;
            end else begin
              tx_data_d   = '0;
              range_err_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.RdAddr   = ptr_q;
  assign bus.WrAddr   = wr_addr_q;
  assign bus.WrData   = wr_data_q;
  assign bus.WrEn     = wr_en_q;
  assign bus.TxData   = tx_data_q;
  assign bus.TxValid  = tx_valid_q;
  assign bus.RangeErr = range_err_q;
  assign bus.Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_register_access_controller.sv
// Bench: two controllers (NumRegs=16 and NumRegs=256) driven with identical
// stimulus, checked against a transaction-level model and a directed table.
module tb_pwm_register_access_controller;

  logic CLK;
  logic RST;

  pwm_register_access_controller_if #(.AddressWidth(8)) if0 ();
  pwm_register_access_controller_if #(.AddressWidth(8)) if1 ();

  pwm_register_access_controller #(.AddressWidth(8), .NumRegs(16)) dut0 (
    .CLK(CLK), .RST(RST), .bus(if0.slave)
  );
  pwm_register_access_controller #(.AddressWidth(8), .NumRegs(256)) dut1 (
    .CLK(CLK), .RST(RST), .bus(if1.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state, per DUT
  localparam int M_IDLE = 0, M_PTR = 1, M_WR = 2, M_RD = 3;
  int          m_mode [2];
  int          m_ptr  [2];
  logic        m_wen  [2];
  logic        m_tval [2];
  logic        m_rerr [2];
  logic [7:0]  m_waddr[2];
  logic [7:0]  m_wdata[2];
  logic [7:0]  m_txd  [2];
  logic [7:0]  mb     [2][256];
  int          nregs  [2];

  // Register bank seen by each DUT
  assign if0.RegRdData = mb[0][if0.RdAddr];
  assign if1.RegRdData = mb[1][if1.RdAddr];

  logic [1:0] a_wen, a_tval, a_rerr, a_busy;
  logic [7:0] a_waddr[2], a_wdata[2], a_txd[2], a_rd[2];
  assign a_wen  = {if1.WrEn, if0.WrEn};
  assign a_tval = {if1.TxValid, if0.TxValid};
  assign a_rerr = {if1.RangeErr, if0.RangeErr};
  assign a_busy = {if1.Busy, if0.Busy};
  assign a_waddr[0] = if0.WrAddr;  assign a_waddr[1] = if1.WrAddr;
  assign a_wdata[0] = if0.WrData;  assign a_wdata[1] = if1.WrData;
  assign a_txd[0]   = if0.TxData;  assign a_txd[1]   = if1.TxData;
  assign a_rd[0]    = if0.RdAddr;  assign a_rd[1]    = if1.RdAddr;

  int checks = 0;
  int failures = 0;

  logic       c_rst, c_sm, c_rnw, c_stop, c_rxv, c_txq;
  logic [7:0] c_rxd;

  typedef struct {
    logic       rst, sm, rnw, stop, rxv;
    logic [7:0] rxd;
    logic       txq;
    logic       wen;
    logic [7:0] waddr, wdata;
    logic       tval;
    logic [7:0] txd;
    logic       rerr, busy;
    logic [7:0] rdaddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, sm, rnw, stop, rxv,
                              input logic [7:0] rxd, input logic txq,
                              input logic wen, input logic [7:0] waddr, wdata,
                              input logic tval, input logic [7:0] txd,
                              input logic rerr, busy, input logic [7:0] rdaddr);
    vec_t v;
    v.rst = rst; v.sm = sm; v.rnw = rnw; v.stop = stop; v.rxv = rxv;
    v.rxd = rxd; v.txq = txq; v.wen = wen; v.waddr = waddr; v.wdata = wdata;
    v.tval = tval; v.txd = txd; v.rerr = rerr; v.busy = busy; v.rdaddr = rdaddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply one edge of the transaction rules to the model of DUT d
  task automatic model_edge(input int d);
    m_wen[d]  = 1'b0;
    m_tval[d] = 1'b0;
    if (c_rst) begin
      m_mode[d] = M_IDLE; m_ptr[d] = 0; m_rerr[d] = 1'b0;
      m_waddr[d] = 8'h00; m_wdata[d] = 8'h00; m_txd[d] = 8'h00;
    end else if (c_sm) begin
      m_mode[d] = c_rnw ? M_RD : M_PTR;
      m_rerr[d] = 1'b0;
    end else if (c_stop) begin
      m_mode[d] = M_IDLE;
    end else if (m_mode[d] == M_PTR && c_rxv) begin
      m_ptr[d]  = int'(c_rxd);
      m_mode[d] = M_WR;
    end else if (m_mode[d] == M_WR && c_rxv) begin
      if (m_ptr[d] < nregs[d]) begin
        m_wen[d] = 1'b1; m_waddr[d] = 8'(m_ptr[d]); m_wdata[d] = c_rxd;
        mb[d][m_ptr[d]] = c_rxd;
      end else begin
        m_rerr[d] = 1'b1;
      end
      m_ptr[d] = (m_ptr[d] + 1) % 256;
    end else if (m_mode[d] == M_RD && c_txq) begin
      m_tval[d] = 1'b1;
      if (m_ptr[d] < nregs[d]) m_txd[d] = mb[d][m_ptr[d]];
      else begin m_txd[d] = 8'h00; m_rerr[d] = 1'b1; end
      m_ptr[d] = (m_ptr[d] + 1) % 256;
    end
  endtask

  task automatic model_check(input int d);
    string p;
    p = $sformatf("dut%0d", d);
    chk({p, ".Busy"},     32'(a_busy[d]), 32'(m_mode[d] != M_IDLE));
    chk({p, ".RdAddr"},   32'(a_rd[d]),   32'(m_ptr[d]));
    chk({p, ".WrEn"},     32'(a_wen[d]),  32'(m_wen[d]));
    chk({p, ".TxValid"},  32'(a_tval[d]), 32'(m_tval[d]));
    chk({p, ".RangeErr"}, 32'(a_rerr[d]), 32'(m_rerr[d]));
    if (m_wen[d] || c_rst) begin
      chk({p, ".WrAddr"}, 32'(a_waddr[d]), 32'(m_waddr[d]));
      chk({p, ".WrData"}, 32'(a_wdata[d]), 32'(m_wdata[d]));
    end
    if (m_tval[d] || c_rst) chk({p, ".TxData"}, 32'(a_txd[d]), 32'(m_txd[d]));
  endtask

  task automatic step(input logic rst, sm, rnw, stop, rxv,
                      input logic [7:0] rxd, input logic txq);
    c_rst = rst; c_sm = sm; c_rnw = rnw; c_stop = stop;
    c_rxv = rxv; c_rxd = rxd; c_txq = txq;
    RST = rst;
    if0.StartMatch = sm; if0.RnW = rnw; if0.Stop = stop;
    if0.RxValid = rxv; if0.RxData = rxd; if0.TxReq = txq;
    if1.StartMatch = sm; if1.RnW = rnw; if1.Stop = stop;
    if1.RxValid = rxv; if1.RxData = rxd; if1.TxReq = txq;
    @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) model_edge(d);
    for (int d = 0; d < 2; d++) model_check(d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    nregs[0] = 16;
    nregs[1] = 256;
    for (int a = 0; a < 256; a++) begin
      mb[0][a] = 8'($urandom);
      mb[1][a] = mb[0][a];
    end
    mb[0][14] = 8'h11; mb[1][14] = 8'h11;
    mb[0][15] = 8'h22; mb[1][15] = 8'h22;

    //            rst sm rnw stp rxv rxd  txq | wen wad  wdat tv txd rerr busy rd
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h03, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h03));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'hAA, 0,   1, 8'h03, 8'hAA, 0, 8'h00, 0, 1, 8'h04));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h55, 0,   1, 8'h04, 8'h55, 0, 8'h00, 0, 1, 8'h05));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h05));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h05));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h0E, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h0E));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h0E));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h0E));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 1, 8'h11, 0, 1, 8'h0F));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 1, 8'h22, 0, 1, 8'h10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 1, 8'h00, 1, 1, 8'h11));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 8'h11));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h11));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h11));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h20, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h20));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h77, 0,   0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 8'h21));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h21));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h05, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h05));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'h99, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h05));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8'h99, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h05));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h06, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h06));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'hAB, 0,   1, 8'h06, 8'hAB, 0, 8'h00, 0, 1, 8'h07));
    tbl.push_back(mk(1, 0, 0, 0, 1, 8'hCD, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00));

    RST = 1'b1;
    foreach (tbl[i]) begin
      vec_t v;
      string p;
      v = tbl[i];
      p = $sformatf("tbl[%0d]", i);
      step(v.rst, v.sm, v.rnw, v.stop, v.rxv, v.rxd, v.txq);
      chk({p, ".Busy"},     32'(if0.Busy),     32'(v.busy));
      chk({p, ".RdAddr"},   32'(if0.RdAddr),   32'(v.rdaddr));
      chk({p, ".WrEn"},     32'(if0.WrEn),     32'(v.wen));
      chk({p, ".TxValid"},  32'(if0.TxValid),  32'(v.tval));
      chk({p, ".RangeErr"}, 32'(if0.RangeErr), 32'(v.rerr));
      if (v.wen || v.rst) begin
        chk({p, ".WrAddr"}, 32'(if0.WrAddr), 32'(v.waddr));
        chk({p, ".WrData"}, 32'(if0.WrData), 32'(v.wdata));
      end
      if (v.tval || v.rst) chk({p, ".TxData"}, 32'(if0.TxData), 32'(v.txd));
    end

    // Pointer wrap on the full 256-register configuration
    step(0, 1, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 1, 8'hFF, 0);
    step(0, 0, 0, 0, 1, 8'h12, 0);
    chk("wrap.WrEn0",   32'(if1.WrEn),   32'd1);
    chk("wrap.WrAddr0", 32'(if1.WrAddr), 32'hFF);
    chk("wrap.WrData0", 32'(if1.WrData), 32'h12);
    step(0, 0, 0, 0, 1, 8'h34, 0);
    chk("wrap.WrEn1",   32'(if1.WrEn),     32'd1);
    chk("wrap.WrAddr1", 32'(if1.WrAddr),   32'h00);
    chk("wrap.WrData1", 32'(if1.WrData),   32'h34);
    chk("wrap.RdAddr",  32'(if1.RdAddr),   32'h01);
    chk("wrap.RangeErr", 32'(if1.RangeErr), 32'd0);
    step(0, 0, 0, 1, 0, 8'h00, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic rst, sm, stop, rxv, txq;
      rst  = ($urandom_range(0, 199) == 0);
      sm   = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 24) == 0);
      rxv  = ($urandom_range(0, 9) < 4);
      txq  = ($urandom_range(0, 9) < 4);
      step(rst, sm, 1'($urandom), stop, rxv, 8'($urandom), txq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
